// File: rtl/cond_flag_unit_if.sv
// Execute-stage bundle between the decoder/ALU side and the condition/flag unit.
// The master drives the instruction controls; the slave returns the gated controls, flags and counters.
interface cond_flag_unit_if #(
    parameter int CNT_W = 16
);
    logic             Valid;
    logic             Stall;
    logic             Flush;
    logic [3:0]       Cond;
    logic [3:0]       ALUFlags;
    logic [1:0]       FlagW;
    logic             PCS;
    logic             RegW;
    logic             MemW;
    logic             NoWrite;
    logic             CntClr;
    logic             CondEx;
    logic             PCSrc;
    logic             RegWrite;
    logic             MemWrite;
    logic [3:0]       Flags;
    logic             Carry;
    logic [CNT_W-1:0] ExecCnt;
    logic [CNT_W-1:0] SkipCnt;

    modport master (
        output Valid, Stall, Flush, Cond, ALUFlags, FlagW,
               PCS, RegW, MemW, NoWrite, CntClr,
        input  CondEx, PCSrc, RegWrite, MemWrite, Flags, Carry,
               ExecCnt, SkipCnt
    );

    modport slave (
        input  Valid, Stall, Flush, Cond, ALUFlags, FlagW,
               PCS, RegW, MemW, NoWrite, CntClr,
        output CondEx, PCSrc, RegWrite, MemWrite, Flags, Carry,
               ExecCnt, SkipCnt
    );
endinterface

// File: rtl/cond_flag_unit.sv
// Architectural NZCV register, ARM condition evaluation, gating of PC/register/memory writes,
// and saturating executed/skipped instruction counters.
module cond_flag_unit #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             Reset,
    cond_flag_unit_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [3:0] flags_q;
    logic [3:0] flags_d;
    logic       cond_ex;
    logic       commit;
    logic [1:0] cnt_inc;

    logic flag_n;
    logic flag_z;
    logic flag_c;
    logic flag_v;

    assign flag_n = flags_q[3];
    assign flag_z = flags_q[2];
    assign flag_c = flags_q[1];
    assign flag_v = flags_q[0];

    // Condition is judged only against committed flags; there is no ALUFlags bypass.
    always_comb begin
        cond_ex = 1'b1;
        case (bus.Cond)
            4'b0000: cond_ex = flag_z;
            4'b0001: cond_ex = ~flag_z;
            4'b0010: cond_ex = flag_c;
            4'b0011: cond_ex = ~flag_c;
            4'b0100: cond_ex = flag_n;
            4'b0101: cond_ex = ~flag_n;
            4'b0110: cond_ex = flag_v;
            4'b0111: cond_ex = ~flag_v;
            4'b1000: cond_ex = flag_c & ~flag_z;
            4'b1001: cond_ex = ~flag_c | flag_z;
            4'b1010: cond_ex = (flag_n == flag_v);
            4'b1011: cond_ex = (flag_n != flag_v);
            4'b1100: cond_ex = ~flag_z & (flag_n == flag_v);
            4'b1101: cond_ex = flag_z | (flag_n != flag_v);
            default: cond_ex = 1'b1;
        endcase
    end

    assign commit = bus.Valid & ~bus.Stall & ~bus.Flush & ~Reset;

    assign bus.CondEx   = cond_ex;
    assign bus.PCSrc    = bus.PCS & cond_ex & commit;
    assign bus.RegWrite = bus.RegW & ~bus.NoWrite & cond_ex & commit;
    assign bus.MemWrite = bus.MemW & cond_ex & commit;
    assign bus.Flags    = flags_q;
    assign bus.Carry    = flags_q[1];

    always_comb begin
        flags_d = flags_q;
        if (commit && cond_ex) begin
            if (bus.FlagW[1]) begin
                flags_d[3:2] = bus.ALUFlags[3:2];
            end
            if (bus.FlagW[0]) begin
                flags_d[1:0] = bus.ALUFlags[1:0];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            flags_q <= 4'b0000;
        end else begin
            flags_q <= flags_d;
        end
    end

    // Counter 0 counts passed commits, counter 1 counts failed commits.
    assign cnt_inc = {commit & ~cond_ex, commit & cond_ex};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (bus.CntClr) begin
                    cnt_d = '0;
                end else if (cnt_inc[gi] && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            always_ff @(posedge CLK) begin
                if (Reset) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

    assign bus.ExecCnt = g_cnt[0].cnt_q;
    assign bus.SkipCnt = g_cnt[1].cnt_q;
endmodule

// File: tb/tb_cond_flag_unit.sv
// Scoreboard bench for cond_flag_unit: expected outputs are queued as each instruction is driven
// and compared mid-cycle against what the DUT presents.
module tb_cond_flag_unit;
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CMAX = '1;

    logic CLK;
    logic Reset;

    cond_flag_unit_if #(.CNT_W(CNT_W)) bus ();

    cond_flag_unit #(.CNT_W(CNT_W)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic             condex;
        logic             pcsrc;
        logic             regwrite;
        logic             memwrite;
        logic [3:0]       flags;
        logic             carry;
        logic [CNT_W-1:0] exec;
        logic [CNT_W-1:0] skip;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0]       m_flags;
    logic [CNT_W-1:0] m_exec;
    logic [CNT_W-1:0] m_skip;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic cond_model(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (c[3:1] == 3'd7) return 1'b1;
        return base ^ c[0];
    endfunction

    // Called just after a rising edge: drive one cycle, queue expectations, compare at the falling edge.
    task automatic drive(input logic rst, input logic v, input logic st, input logic fl,
                         input logic [3:0] cond, input logic [3:0] alu, input logic [1:0] fw,
                         input logic pcs, input logic regw, input logic memw,
                         input logic nowr, input logic clr);
        exp_t e, o;
        logic ce, cm;
        Reset        = rst;
        bus.Valid    = v;
        bus.Stall    = st;
        bus.Flush    = fl;
        bus.Cond     = cond;
        bus.ALUFlags = alu;
        bus.FlagW    = fw;
        bus.PCS      = pcs;
        bus.RegW     = regw;
        bus.MemW     = memw;
        bus.NoWrite  = nowr;
        bus.CntClr   = clr;

        ce = cond_model(cond, m_flags);
        cm = v && !st && !fl && !rst;
        e.condex   = ce;
        e.pcsrc    = pcs && ce && cm;
        e.regwrite = regw && !nowr && ce && cm;
        e.memwrite = memw && ce && cm;
        e.flags    = m_flags;
        e.carry    = m_flags[1];
        e.exec     = m_exec;
        e.skip     = m_skip;
        sb_q.push_back(e);

        @(negedge CLK);
        o = sb_q.pop_front();
        check_eq("CondEx",   32'(bus.CondEx),   32'(o.condex));
        check_eq("PCSrc",    32'(bus.PCSrc),    32'(o.pcsrc));
        check_eq("RegWrite", 32'(bus.RegWrite), 32'(o.regwrite));
        check_eq("MemWrite", 32'(bus.MemWrite), 32'(o.memwrite));
        check_eq("Flags",    32'(bus.Flags),    32'(o.flags));
        check_eq("Carry",    32'(bus.Carry),    32'(o.carry));
        check_eq("ExecCnt",  32'(bus.ExecCnt),  32'(o.exec));
        check_eq("SkipCnt",  32'(bus.SkipCnt),  32'(o.skip));
        $display("t=%0t rst=%0b v=%0b st=%0b fl=%0b cond=%h alu=%h fw=%b -> ce=%0b pcs=%0b rw=%0b mw=%0b flags=%h exec=%0d skip=%0d",
                 $time, rst, v, st, fl, cond, alu, fw, bus.CondEx, bus.PCSrc, bus.RegWrite,
                 bus.MemWrite, bus.Flags, bus.ExecCnt, bus.SkipCnt);

        @(posedge CLK);
        if (rst) begin
            m_flags = 4'b0000;
            m_exec  = '0;
            m_skip  = '0;
        end else begin
            if (cm && ce) begin
                if (fw[1]) m_flags[3:2] = alu[3:2];
                if (fw[0]) m_flags[1:0] = alu[1:0];
            end
            if (clr) begin
                m_exec = '0;
                m_skip = '0;
            end else if (cm && ce) begin
                if (m_exec != CMAX) m_exec = m_exec + 1'b1;
            end else if (cm) begin
                if (m_skip != CMAX) m_skip = m_skip + 1'b1;
            end
        end
        #1;
    endtask

    // Plain committed instruction shortcut.
    task automatic instr(input logic [3:0] cond, input logic [3:0] alu, input logic [1:0] fw,
                         input logic pcs, input logic regw, input logic memw, input logic nowr);
        drive(1'b0, 1'b1, 1'b0, 1'b0, cond, alu, fw, pcs, regw, memw, nowr, 1'b0);
    endtask

    initial begin
        Reset = 1'b1;
        bus.Valid = 1'b0; bus.Stall = 1'b0; bus.Flush = 1'b0; bus.Cond = 4'h0;
        bus.ALUFlags = 4'h0; bus.FlagW = 2'b00; bus.PCS = 1'b0; bus.RegW = 1'b0;
        bus.MemW = 1'b0; bus.NoWrite = 1'b0; bus.CntClr = 1'b0;
        m_flags = 4'b0000; m_exec = '0; m_skip = '0;
        @(posedge CLK);
        #1;

        // Reset held with a live instruction: gates forced low, nothing recorded.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'hE, 4'hF, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'hE, 4'hF, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

        // EQ fails, NE passes on post-reset flags.
        instr(4'h0, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        instr(4'h1, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);

        // CMP equal then BEQ with no bypass.
        instr(4'hE, 4'h6, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1);
        instr(4'h0, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);

        // Independent partial writes.
        instr(4'hE, 4'h9, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        instr(4'hE, 4'h6, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
        instr(4'hE, 4'hA, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        instr(4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Stall blocks everything; release lets the update through.
        drive(1'b0, 1'b1, 1'b1, 1'b0, 4'hE, 4'hF, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 4'hE, 4'hF, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

        // Flush, alone and together with Stall.
        drive(1'b0, 1'b1, 1'b0, 1'b1, 4'hE, 4'h0, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 4'hE, 4'h0, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'hE, 4'h0, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

        // Reset mid-stream drops a pending flag write.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'hE, 4'h5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        instr(4'h0, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        instr(4'h1, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);

        // Condition sweep: load each flag value, then evaluate all codes without committing.
        for (int f = 0; f < 16; f++) begin
            instr(4'hE, 4'(f), 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
            for (int c = 0; c < 16; c++) begin
                drive(1'b0, 1'b0, 1'b0, 1'b0, 4'(c), 4'h0, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
            end
        end

        // Counter saturation and clear-over-increment.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) instr(4'hE, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 4'hE, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 18; i++) instr(4'h0, 4'h0, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
        instr(4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Randomised tail.
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 40) == 0), 1'($urandom), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 5) == 0), 4'($urandom), 4'($urandom), 2'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 30) == 0));
        end

        check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/cond_flag_unit.md
Name: cond_flag_unit

Overview:
- Execute-stage consumer of the ALU's NZCV flags.
- Holds the architectural flag register and evaluates the 4-bit ARM condition field against it.
- Gates the PCSrc, RegWrite and MemWrite controls, and returns the stored C flag to the ALU as its Carry input for ADC/SBC/RSC.
- Keeps saturating counters of executed and condition-failed instructions for debug and perf.

Parameters:
CNT_W, 16, width of the ExecCnt and SkipCnt counters.

Ports:
CLK  input  1  clock, rising edge
Reset  input  1  synchronous, active-high reset
Valid  input  1  an instruction is present in the execute stage this cycle
Stall  input  1  execute stage is held; no commit this cycle
Flush  input  1  execute-stage instruction is squashed
Cond  input  4  instruction condition field [31:28]
ALUFlags  input  4  {N,Z,C,V} from the ALU for the current instruction
FlagW  input  2  [1]=update N,Z; [0]=update C,V (the S-bit decoded per opcode class)
PCS  input  1  decoder: instruction writes the PC
RegW  input  1  decoder: instruction writes the register file
MemW  input  1  decoder: instruction writes memory
NoWrite  input  1  CMP/CMN/TST/TEQ; suppresses RegWrite only
CntClr  input  1  synchronous clear of both counters
CondEx  output  1  condition passed (combinational)
PCSrc  output  1  gated PCS
RegWrite  output  1  gated RegW & ~NoWrite
MemWrite  output  1  gated MemW
Flags  output  4  registered {N,Z,C,V}
Carry  output  1  equals Flags[1]; feeds the ALU Carry input
ExecCnt  output  CNT_W  committed instructions whose condition passed
SkipCnt  output  CNT_W  committed instructions whose condition failed

Behaviour:
- Reset (synchronous, active-high):
  - Flags=4'b0000, ExecCnt=0, SkipCnt=0.
  - While Reset=1, PCSrc, RegWrite and MemWrite are forced 0.
- CondEx is evaluated from the registered Flags, not from ALUFlags. Encodings:
  - 0000 EQ: Z. 0001 NE: ~Z.
  - 0010 CS: C. 0011 CC: ~C.
  - 0100 MI: N. 0101 PL: ~N.
  - 0110 VS: V. 0111 VC: ~V.
  - 1000 HI: C&~Z. 1001 LS: ~C|Z.
  - 1010 GE: N==V. 1011 LT: N!=V.
  - 1100 GT: ~Z&(N==V). 1101 LE: Z|(N!=V).
  - 1110 AL: 1. 1111: 1 (unconditional).
- Commit: commit = Valid & ~Stall & ~Flush & ~Reset.
- Gated control outputs (combinational, zero latency):
  - PCSrc = PCS & CondEx & commit.
  - RegWrite = RegW & ~NoWrite & CondEx & commit.
  - MemWrite = MemW & CondEx & commit.
- Flag update on the rising edge when commit & CondEx:
  - FlagW[1]=1: N,Z <= ALUFlags[3:2].
  - FlagW[0]=1: C,V <= ALUFlags[1:0].
  - The two groups are independent. FlagW=00 leaves Flags unchanged.
- Flags are never updated while Stall, Flush or ~Valid is asserted, or when the condition fails.
- Flag timing: new Flags become visible to CondEx and Carry in the cycle after the write. Back-to-back CMP then BEQ works with no bypass. No forwarding from ALUFlags exists inside this block.
- Counters, priority Reset > CntClr > increment:
  - commit & CondEx: ExecCnt+1.
  - commit & ~CondEx: SkipCnt+1.
  - Both counters saturate at 2^CNT_W-1 and do not wrap.
  - CntClr in the same cycle as a commit clears the counter; the increment is dropped.
- Stall=1 and Flush=1 together behave as Flush: no commit, no update.
- Reset mid-stream discards any in-flight update. The first post-reset instruction sees Flags=0000, so EQ fails and NE passes.

Test Plan:
- Reset, then Valid=1, Cond=0000 (EQ), RegW=1 -> CondEx=0, RegWrite=0, SkipCnt=1 next cycle; Cond=0001 (NE) -> RegWrite=1, ExecCnt=1.
- CMP equal: Cond=1110, FlagW=11, NoWrite=1, RegW=1, ALUFlags=0110 -> RegWrite=0; next cycle Flags=0110, Carry=1; BEQ (Cond=0000, PCS=1) -> PCSrc=1.
- Partial write: Flags=1001, FlagW=10, ALUFlags=0110 -> Flags=0101. Then FlagW=01, ALUFlags=1010 -> Flags=0110.
- Stall: Stall=1 with AL, FlagW=11, ALUFlags=1111 -> PCSrc/RegWrite/MemWrite=0, Flags unchanged, counters unchanged. Deassert Stall -> update occurs.
- Flush plus condition sweep: Flush=1 with AL and MemW=1 -> MemWrite=0, no count. Then sweep all 16 Cond codes over all 16 Flags values and check CondEx against the encoding list (256 checks).
- Counter edges: CNT_W=4, 20 committed AL instructions -> ExecCnt holds at 15. CntClr asserted with a commit in the same cycle -> ExecCnt=0.
